// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared types and constants for the stack arbiter
package stack_pkg;

    localparam int DATA_W = 8;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/stack_arbiter_if.sv
// rtl/stack_arbiter_if.sv - requester and stack-core signal bundle for stack_arbiter
interface stack_arbiter_if #(
    parameter int DATA_W = stack_pkg::DATA_W
);
    logic [1:0]          req;
    logic [1:0]          op;
    logic [2*DATA_W-1:0] wdata;
    logic [1:0]          gnt;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;
    logic                stk_push;
    logic                stk_pop;
    logic [DATA_W-1:0]   stk_wdata;
    logic [DATA_W-1:0]   stk_rdata;
    logic                stk_done;
    logic                stk_empty;
    logic                stk_full;

    // Requesters plus stack core, i.e. everything around the arbiter
    modport master (
        output req, op, wdata, stk_rdata, stk_done, stk_empty, stk_full,
        input  gnt, rsp_valid, rsp_data, rsp_err, stk_push, stk_pop, stk_wdata
    );

    // The arbiter itself
    modport slave (
        input  req, op, wdata, stk_rdata, stk_done, stk_empty, stk_full,
        output gnt, rsp_valid, rsp_data, rsp_err, stk_push, stk_pop, stk_wdata
    );
endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin selector
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_rr_last,
    output logic       o_valid,
    output logic       o_winner
);
    // Contention goes to whoever was not served last; a lone requester always wins
    always_comb begin
        o_valid  = |i_req;
        o_winner = 1'b0;
        if (i_req == 2'b11) begin
            o_winner = ~i_rr_last;
        end else begin
            o_winner = i_req[1];
        end
    end
endmodule

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - two-requester round-robin front end for a shared LIFO core; optional WAIT timeout via STACK_ARB_TIMEOUT_EN
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int DATA_W  = stack_pkg::DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    stack_arbiter_if.slave  bus
);
    arb_state_t        r_state;
    logic              r_owner;
    logic              r_op;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rr_last;
    logic [1:0]        r_gnt;
    logic [1:0]        r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic              r_push;
    logic              r_pop;

    logic              w_valid;
    logic              w_winner;
    logic              w_illegal;

`ifdef STACK_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  r_cnt;
`else
    // WAIT is unbounded in this build, so the timeout length has no effect here
    localparam int unused_timeout = TIMEOUT;
`endif

    rr_pick2 u_pick (
        .i_req     (bus.req),
        .i_rr_last (r_rr_last),
        .o_valid   (w_valid),
        .o_winner  (w_winner)
    );

    // An operation the core cannot legally accept is answered locally with an error
    always_comb begin
        w_illegal = ((r_op == OP_POP) && bus.stk_empty) || ((r_op == OP_PUSH) && bus.stk_full);
    end

    // Arbitration FSM: grant, issue to core, wait for completion, respond to owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_op        <= 1'b0;
            r_wdata     <= '0;
            r_rr_last   <= 1'b1;
            r_gnt       <= 2'b00;
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_push      <= 1'b0;
            r_pop       <= 1'b0;
`ifdef STACK_ARB_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_gnt       <= 2'b00;
            r_rsp_valid <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_owner <= w_winner;
                        r_op    <= bus.op[w_winner];
                        r_wdata <= w_winner ? bus.wdata[2*DATA_W-1:DATA_W] : bus.wdata[DATA_W-1:0];
                        r_gnt   <= w_winner ? 2'b10 : 2'b01;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_illegal) begin
                        r_rsp_err  <= 1'b1;
                        r_rsp_data <= '0;
                        r_state    <= RESP;
                    end else begin
                        r_push  <= (r_op == OP_PUSH);
                        r_pop   <= (r_op == OP_POP);
`ifdef STACK_ARB_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.stk_done) begin
                        r_push     <= 1'b0;
                        r_pop      <= 1'b0;
                        r_rsp_data <= (r_op == OP_POP) ? bus.stk_rdata : '0;
                        r_rsp_err  <= 1'b0;
                        r_state    <= RESP;
                    end
`ifdef STACK_ARB_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_push     <= 1'b0;
                        r_pop      <= 1'b0;
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                    r_rr_last   <= r_owner;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.stk_push  = r_push;
    assign bus.stk_pop   = r_pop;
    assign bus.stk_wdata = r_wdata;
endmodule
